apb_cmd_master: RTL and testbench

APB initiator that turns single-word read/write commands from an internal valid/ready command port into APB transfers. It drives the SETUP and ACCESS phases, waits for `pready`, captures `prdata` and `pslverr`, and returns one response per command. It sits between on-chip control logic (boot sequencer, debug/UART bridge) and the APB configuration-register slaves of the Ethernet datapath. One transfer is outstanding at a time.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_cmd_master.sv | 111 +++++++++++
 tb/tb_apb_cmd_master.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// Shared APB definitions: master FSM state encoding and default bus widths
// used by the APB command master and the APB slave register blocks.
package apb_pkg;

  localparam int APB_DEF_ADDR_WIDTH = 32;
  localparam int APB_DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// APB initiator: turns single-word valid/ready read/write commands into APB
// SETUP/ACCESS transfers and returns one response per command (with timeout).
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = APB_DEF_ADDR_WIDTH,
  parameter int APB_DATA_WIDTH = APB_DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Count value at which one more stalled ACCESS cycle reaches the limit.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_mst_state_t   state, next_state;
  logic [CNT_W-1:0] to_cnt;
  logic             accept;
  logic             to_hit;

  assign cmd_ready = (state == IDLE) && presetn;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // A pready arriving on the limit cycle wins over the timeout.
  assign to_hit    = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && !pready &&
                     (to_cnt == TO_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (pready || to_hit) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      to_cnt      <= '0;
    end else begin
      psel    <= (next_state == SETUP) || (next_state == ACCESS);
      penable <= (next_state == ACCESS);

      if (accept) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_write ? cmd_wdata : '0;
      end

      if (state == SETUP) begin
        to_cnt <= '0;
      end else if (state == ACCESS && !pready && to_cnt != '1) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (state == ACCESS && pready) begin
        rsp_valid   <= 1'b1;
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
      end else if (to_hit) begin
        rsp_valid   <= 1'b1;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// Scoreboard bench for apb_cmd_master against a behavioural APB slave with
// programmable wait states, error response and stuck-low pready.
module tb_apb_cmd_master;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic        psel, penable, pwrite;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  always #5 pclk = ~pclk;

  apb_cmd_master #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  // Behavioural slave
  int          slv_wait = 0;
  bit          slv_err = 1'b0, slv_stuck = 1'b0;
  int          wcnt = 0;
  logic [31:0] mem [logic [31:0]];

  always @(negedge pclk) begin
    pslverr = slv_err;
    if (psel && penable && !slv_stuck && wcnt >= slv_wait) begin
      pready = 1'b1;
      if (pwrite)                  prdata = 32'h5555_AAAA;
      else if (mem.exists(paddr))  prdata = mem[paddr];
      else                         prdata = 32'hA5A5_A5A5;
    end else begin
      pready = 1'b0;
      prdata = 32'hFFFF_FFFF;
    end
  end

  always @(posedge pclk) begin
    if (psel && penable) begin
      if (pready) begin
        wcnt <= 0;
        if (pwrite && !pslverr) mem[paddr] = pwdata;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // Response monitor
  always @(negedge pclk) begin
    if (presetn && rsp_valid && rsp_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b to=%b, none expected",
                 rsp_rdata, rsp_err, rsp_timeout);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err || rsp_timeout !== e.to) begin
          miscompares++;
          $display("FAIL rsp: got rdata=%h err=%b to=%b, expected rdata=%h err=%b to=%b",
                   rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input logic ee, input logic eto,
                       input bit push);
    bit ok = 1'b0;
    if (push) exp_q.push_back(rsp_t'{erd, ee, eto});
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge pclk);
      if (cmd_ready) ok = 1'b1;
    end
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_rsp();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge pclk);
      if (rsp_valid && rsp_ready) seen = 1'b1;
    end
    chk("rsp_seen", {31'd0, seen}, 32'd1);
    @(posedge pclk);
    #1;
  endtask

  // Counts ACCESS cycles up to the response; flags any paddr/pwrite/pwdata change.
  task automatic count_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                              output int acc, output bit stable);
    bit done = 1'b0;
    acc = 0;
    stable = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge pclk);
      if (psel && penable) begin
        acc++;
        if (paddr !== a || pwrite !== w || pwdata !== d) stable = 1'b0;
      end
      if (rsp_valid) done = 1'b1;
    end
    @(posedge pclk);
    #1;
  endtask

  initial begin
    int  c1, c2, acc;
    bit  stable, ok;

    // Reset state
    repeat (3) @(negedge pclk);
    chk("rst_psel", {31'd0, psel}, 32'd0);
    chk("rst_penable", {31'd0, penable}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_err_to", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    @(posedge pclk);
    #1 presetn = 1'b1;
    @(negedge pclk);
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge pclk);
    #1;

    // Zero-wait write: phase timing relative to the accept edge
    issue(1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge pclk);
    chk("w_c1_psel_pen", {30'd0, psel, penable}, 32'b10);
    chk("w_c1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("w_c1_busy", {31'd0, busy}, 32'd1);
    chk("w_c1_paddr", paddr, 32'h8);
    chk("w_c1_pwdata", pwdata, 32'hDEAD_BEEF);
    @(negedge pclk);
    chk("w_c2_psel_pen", {30'd0, psel, penable}, 32'b11);
    chk("w_c2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge pclk);
    chk("w_c3_psel_pen", {30'd0, psel, penable}, 32'b00);
    chk("w_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge pclk);
    #1;

    // Read back the written register
    issue(1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    wait_rsp();

    // Back-to-back commands with cmd_valid held: 4-cycle period
    mem[32'h4] = 32'h1234_5678;
    issue(1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    c1 = acc_cyc;
    issue(1'b1, 32'hC, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b1);
    c2 = acc_cyc;
    chk("cmd_period", c2 - c1, 32'd4);
    wait_rsp();

    // Read with 3 wait states; write data ignored for reads
    slv_wait = 3;
    issue(1'b0, 32'h4, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    count_access(32'h4, 1'b0, 32'h0, acc, stable);
    chk("wait3_access_cycles", acc, 32'd4);
    chk("wait3_stable", {31'd0, stable}, 32'd1);
    slv_wait = 0;

    // Slave error on write and on read
    slv_err = 1'b1;
    issue(1'b1, 32'h100, 32'h0BAD_F00D, 32'h0, 1'b1, 1'b0, 1'b1);
    wait_rsp();
    issue(1'b0, 32'h4, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    wait_rsp();
    slv_err = 1'b0;

    // pready on the limit cycle wins over the timeout
    slv_wait = 15;
    issue(1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    count_access(32'h4, 1'b0, 32'h0, acc, stable);
    chk("limit_access_cycles", acc, 32'd16);
    slv_wait = 0;

    // Stuck pready: timeout after 16 ACCESS cycles
    slv_stuck = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    count_access(32'h20, 1'b0, 32'h0, acc, stable);
    chk("timeout_access_cycles", acc, 32'd16);
    slv_stuck = 1'b0;

    // Response back-pressure with a second command pending
    rsp_ready = 1'b0;
    issue(1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge pclk);
      if (rsp_valid) ok = 1'b1;
    end
    chk("hold_rsp_seen", {31'd0, ok}, 32'd1);
    exp_q.push_back(rsp_t'{32'hDEAD_BEEF, 1'b0, 1'b0});
    cmd_write = 1'b0;
    cmd_addr  = 32'h8;
    cmd_wdata = 32'h0;
    cmd_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      if (!rsp_valid || rsp_rdata !== 32'h1234_5678 || rsp_err || rsp_timeout ||
          cmd_ready || psel || !busy) stable = 1'b0;
    end
    chk("hold_stable", {31'd0, stable}, 32'd1);
    @(posedge pclk);
    #1 rsp_ready = 1'b1;
    @(negedge pclk);
    chk("hold_hs_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge pclk);
    chk("post_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_hs_psel", {31'd0, psel}, 32'd0);
    @(negedge pclk);
    chk("second_cmd_psel", {31'd0, psel}, 32'd1);
    cmd_valid = 1'b0;
    wait_rsp();

    // Reset asserted during ACCESS
    slv_stuck = 1'b1;
    issue(1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge pclk);
      if (penable) ok = 1'b1;
    end
    chk("rst_mid_access", {31'd0, ok}, 32'd1);
    #2 presetn = 1'b0;
    #1;
    chk("rst_mid_psel_pen", {30'd0, psel, penable}, 32'b00);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    slv_stuck = 1'b0;
    @(posedge pclk);
    #1 presetn = 1'b1;
    @(negedge pclk);
    chk("rst_rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (rsp_valid || psel) stable = 1'b0;
    end
    chk("rst_no_stale", {31'd0, stable}, 32'd1);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
